// File: rtl/reg_ctrl_pkg.sv
// reg_ctrl_pkg: downstream register function-select codes and the word fetch FSM states
package reg_ctrl_pkg;
  localparam logic [2:0] FS_DEC   = 3'b000;
  localparam logic [2:0] FS_INC   = 3'b001;
  localparam logic [2:0] FS_LOAD  = 3'b010;
  localparam logic [2:0] FS_CLR   = 3'b011;
  localparam logic [2:0] FS_LOAD8 = 3'b100;
  localparam logic [2:0] FS_WRLO  = 3'b101;
  localparam logic [2:0] FS_WRHI  = 3'b110;
  localparam logic [2:0] FS_SIGN  = 3'b111;
  typedef enum logic [2:0] {IDLE, REQ_LO, WR_LO, REQ_HI, WR_HI, FIN} wfs_state_e;
  function automatic logic is_req(input wfs_state_e s);
    return s == REQ_LO || s == REQ_HI;
  endfunction
endpackage

// File: rtl/ack_timer.sv
// ack_timer: reloadable down-counter flagging a memory acknowledge wait that ran out
module ack_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // loaded with TIMEOUT-1 so the count reaches zero in the TIMEOUT-th waiting cycle
  always_comb cnt_d = load_i ? CW'(TIMEOUT - 1) : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired_o = cnt_q == '0;
endmodule

// File: rtl/word_fetch_sequencer.sv
// word_fetch_sequencer: fetches a little-endian byte pair and writes it into a 16-bit register
// Optional macro WFS_TIMEOUT_EN adds an acknowledge timeout that ends the fetch with Err.
module word_fetch_sequencer
  import reg_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Addr,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemAck,
  input  logic [7:0]        MemData,
  output logic [15:0]       RegI,
  output logic              RegE,
  output logic [2:0]        RegFunSel,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);
  wfs_state_e state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [7:0] byte_q;
  logic expired, to_hit;
  assign to_hit = is_req(state_q) && !MemAck && expired;
`ifdef WFS_TIMEOUT_EN
  logic to_q;
  ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i    (Clock),
    .rst_i    (Reset),
    .load_i   (is_req(state_d) && state_d != state_q),
    .en_i     (is_req(state_q)),
    .expired_o(expired)
  );
  // FIN is reached either from WR_HI or from a timeout, so the previous cycle's hit marks Err
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) to_q <= 1'b0;
    else to_q <= to_hit;
  assign Err = Done && to_q;
`else
  assign expired = 1'b0;
  assign Err = 1'b0;
`endif
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      base_q <= '0;
      byte_q <= '0;
    end else begin
      base_q <= (state_q == IDLE && Start) ? Addr : base_q;
      byte_q <= (is_req(state_q) && MemAck) ? MemData : byte_q;
    end
  always_comb
    state_d = state_q == IDLE   ? (Start ? REQ_LO : IDLE) :
              state_q == REQ_LO ? (MemAck ? WR_LO : to_hit ? FIN : REQ_LO) :
              state_q == WR_LO  ? REQ_HI :
              state_q == REQ_HI ? (MemAck ? WR_HI : to_hit ? FIN : REQ_HI) :
              state_q == WR_HI  ? FIN : IDLE;
  always_comb begin
    MemReq    = is_req(state_q);
    MemAddr   = state_q == REQ_LO ? base_q : state_q == REQ_HI ? base_q + ADDR_W'(1) : '0;
    RegE      = state_q == WR_LO || state_q == WR_HI;
    RegFunSel = state_q == WR_LO ? FS_WRLO : state_q == WR_HI ? FS_WRHI : FS_DEC;
    RegI      = RegE ? {8'h00, byte_q} : 16'h0000;
    Busy      = state_q != IDLE;
    Done      = state_q == FIN;
  end
endmodule

// File: tb/tb_word_fetch_sequencer.sv
// tb_word_fetch_sequencer: table-driven fetches against a memory responder and register-write scoreboard
module tb_word_fetch_sequencer;
  import reg_ctrl_pkg::*;
  logic Clock = 1'b0, Reset = 1'b0, Start = 1'b0, MemAck = 1'b0;
  logic [15:0] Addr = '0;
  logic [7:0] MemData = '0;
  logic [15:0] MemAddr, RegI;
  logic MemReq, RegE, Busy, Done, Err;
  logic [2:0] RegFunSel;
  int n_cmp = 0, n_bad = 0;
  logic [15:0] dreg = '0;
  logic [18:0] wr_q[$];
  logic [15:0] addr_q[$];
  typedef struct {
    logic [15:0] addr;
    logic [7:0] lo;
    logic [7:0] hi;
    int dly;
    bit poke;
    logic [15:0] a_lo;
    logic [15:0] a_hi;
    int done_cyc;
    logic [15:0] word;
  } vec_t;
  vec_t vt[6];
  always #5 Clock = ~Clock;
  word_fetch_sequencer #(.ADDR_W(16), .TIMEOUT(15)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Addr(Addr),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck), .MemData(MemData),
    .RegI(RegI), .RegE(RegE), .RegFunSel(RegFunSel),
    .Busy(Busy), .Done(Done), .Err(Err)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic model_write();
    if (RegFunSel == FS_WRLO) dreg[7:0] = RegI[7:0];
    if (RegFunSel == FS_WRHI) dreg[15:8] = RegI[7:0];
  endtask
  task automatic run_fetch(input vec_t v, input string tag);
    int cyc, nreq, nack, nwe;
    bit done;
    wr_q.push_back({FS_WRLO, 8'h00, v.lo});
    wr_q.push_back({FS_WRHI, 8'h00, v.hi});
    addr_q.push_back(v.a_lo);
    addr_q.push_back(v.a_hi);
    Start = 1'b1;
    Addr = v.addr;
    @(negedge Clock);
    Start = v.poke;
    if (v.poke) Addr = 16'hDEAD;
    cyc = 1; nreq = 0; nack = 0; nwe = 0; done = 0;
    while (!done && cyc < 200) begin
      MemAck = 1'b0;
      if (MemReq) begin
        nreq++;
        if (nreq > v.dly) begin
          MemAck = 1'b1;
          MemData = nack == 0 ? v.lo : v.hi;
          nack++;
          nreq = 0;
          if (addr_q.size() > 0) chk({tag, "_memaddr"}, MemAddr, addr_q.pop_front());
          else chk({tag, "_extra_req"}, nack, 2);
        end
      end else MemAck = v.poke;
      if (RegE) begin
        nwe++;
        model_write();
        if (wr_q.size() > 0) chk({tag, "_write"}, {RegFunSel, RegI}, wr_q.pop_front());
        else chk({tag, "_extra_write"}, nwe, 2);
      end
      if (Done) begin
        done = 1;
        chk({tag, "_done_cycle"}, cyc, v.done_cyc);
        chk({tag, "_err"}, Err, 0);
      end else begin
        @(negedge Clock);
        cyc++;
      end
    end
    if (!done) chk({tag, "_done_seen"}, 0, 1);
    chk({tag, "_write_count"}, nwe, 2);
    chk({tag, "_word"}, dreg, v.word);
    chk({tag, "_queues_empty"}, wr_q.size() + addr_q.size(), 0);
    wr_q.delete();
    addr_q.delete();
    @(negedge Clock);
    chk({tag, "_idle_after"}, Busy, 0);
    Start = 1'b0;
    MemAck = 1'b0;
  endtask
  initial begin
    int cyc, nwe;
    vt[0] = '{16'h1234, 8'hCD, 8'hAB, 0, 1'b0, 16'h1234, 16'h1235, 5, 16'hABCD};
    vt[1] = '{16'hFFFF, 8'h11, 8'h22, 0, 1'b0, 16'hFFFF, 16'h0000, 5, 16'h2211};
    vt[2] = '{16'h0100, 8'h5A, 8'hA5, 3, 1'b0, 16'h0100, 16'h0101, 11, 16'hA55A};
    vt[3] = '{16'h00FE, 8'h3C, 8'hC3, 1, 1'b1, 16'h00FE, 16'h00FF, 7, 16'hC33C};
    vt[4] = '{16'h7FFF, 8'h01, 8'h80, 2, 1'b1, 16'h7FFF, 16'h8000, 9, 16'h8001};
    vt[5] = '{16'h4000, 8'h12, 8'h34, 0, 1'b0, 16'h4000, 16'h4001, 5, 16'h3412};
    #1 Reset = 1'b1;
    #1 chk("reset_outputs", {MemReq, MemAddr, RegI, RegE, RegFunSel, Busy, Done, Err}, 64'h0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      MemAck = 1'b1;
      MemData = 8'hFF;
      @(negedge Clock);
      chk("idle_spurious_ack", {Busy, RegE, MemReq}, 0);
    end
    MemAck = 1'b0;
    for (int i = 0; i < 5; i++) run_fetch(vt[i], $sformatf("vec%0d", i));
    // abort while waiting for the high byte
    Start = 1'b1;
    Addr = 16'h4000;
    @(negedge Clock);
    Start = 1'b0;
    MemAck = 1'b1;
    MemData = 8'h77;
    @(negedge Clock);
    MemAck = 1'b0;
    chk("abort_wr_lo", {RegE, RegFunSel, RegI}, {1'b1, FS_WRLO, 16'h0077});
    @(negedge Clock);
    chk("abort_req_hi", {MemReq, MemAddr}, {1'b1, 16'h4001});
    #2 Reset = 1'b1;
    #1 chk("abort_outputs", {MemReq, MemAddr, RegI, RegE, RegFunSel, Busy, Done, Err}, 64'h0);
    @(negedge Clock);
    Reset = 1'b0;
    MemAck = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      chk("after_abort_quiet", {Busy, RegE, Done}, 0);
    end
    MemAck = 1'b0;
    run_fetch(vt[5], "post_abort");
`ifdef WFS_TIMEOUT_EN
    Start = 1'b1;
    Addr = 16'h2000;
    @(negedge Clock);
    Start = 1'b0;
    MemAck = 1'b0;
    cyc = 1;
    nwe = 0;
    while (!Done && cyc < 100) begin
      if (RegE) nwe++;
      @(negedge Clock);
      cyc++;
    end
    chk("timeout_done_cycle", cyc, 16);
    chk("timeout_err", {Done, Err}, 2'b11);
    chk("timeout_no_write", nwe, 0);
    @(negedge Clock);
    chk("timeout_idle_after", {Busy, Err}, 0);
`else
    cyc = 0;
    nwe = 0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
